fifo_rd_adapter: RTL and testbench

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

---
 rtl/fifo_rd_adapter.sv | 93 +++++++++
 tb/tb_fifo_rd_adapter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_adapter.sv
// Read-side adapter turning a 1-cycle-latency fifoSync into a valid/ready stream via a 2-entry skid buffer.
// Optional FIFO_RD_ADAPTER_CNT_EN adds a 16-bit downstream transfer counter output xferCount.
module fifo_rd_adapter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             empty,
  output logic             rdEn,
  input  logic [WIDTH-1:0] dataIn,
  output logic             outValid,
  input  logic             outReady,
`ifdef FIFO_RD_ADAPTER_CNT_EN
  output logic [15:0]      xferCount,
`endif
  output logic [WIDTH-1:0] outData
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] spare_q, spare_d;
  logic             xfer;
  logic [2:0]       load;

  assign outValid = (state_q != EMPTY);
  assign outData  = head_q;
  assign xfer     = outValid & outReady;

  // Occupancy after this edge, counting the word already in flight; reset holds off new pops.
  assign load = 3'(state_q) + 3'(inflight_q) - 3'(xfer);
  assign rdEn = rstN & ~empty & (load <= 3'd1);

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      spare_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      spare_q    <= spare_d;
    end
  end

  // Next-state: promote spare on transfer, land the in-flight word at the tail
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    spare_d    = spare_q;
    inflight_d = rdEn;

    if (xfer) head_d = spare_q;

    if (inflight_q) begin
      if ((state_q == EMPTY) || ((state_q == ONE) && xfer)) head_d = dataIn;
      else spare_d = dataIn;
    end

    case (state_q)
      EMPTY: if (inflight_q) state_d = ONE;
      ONE: begin
        if (inflight_q && !xfer) state_d = TWO;
        else if (!inflight_q && xfer) state_d = EMPTY;
      end
      TWO: if (!inflight_q && xfer) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

`ifdef FIFO_RD_ADAPTER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  assign xfer_cnt_d = xfer ? (xfer_cnt_q + 16'd1) : xfer_cnt_q;
  assign xferCount  = xfer_cnt_q;

  // Free-running transfer count, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) xfer_cnt_q <= '0;
    else       xfer_cnt_q <= xfer_cnt_d;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter: fifoSync read model, occupancy model and an in-order scoreboard.
module tb_fifo_rd_adapter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rstN;
  logic             empty;
  logic             rdEn;
  logic [WIDTH-1:0] dataIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
`ifdef FIFO_RD_ADAPTER_CNT_EN
  logic [15:0]      xferCount;
`endif

  fifo_rd_adapter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .empty    (empty),
    .rdEn     (rdEn),
    .dataIn   (dataIn),
    .outValid (outValid),
    .outReady (outReady),
`ifdef FIFO_RD_ADAPTER_CNT_EN
    .xferCount(xferCount),
`endif
    .outData  (outData)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int               cnt_m = 0;
  bit               inf_m = 1'b0;
  int               step_n = 0;
  int               first_xfer = -1;
  int               last_xfer = -1;
  int               n_xfer = 0;
  int               pops = 0;
  int               max_load = 0;
  logic [WIDTH-1:0] first_data;
  logic [15:0]      xc_m = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(WIDTH'(base + i));
      exp_q.push_back(WIDTH'(base + i));
    end
    empty = (fifo_q.size() == 0);
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    cnt_m = 0;
    inf_m = 1'b0;
    xc_m  = 16'd0;
  endtask

  task automatic new_phase();
    step_n = 0; first_xfer = -1; last_xfer = -1; n_xfer = 0; pops = 0; max_load = 0;
  endtask

  // One clock: check at the settled point before the edge, then play the fifoSync side after it
  task automatic step();
    bit xfer_e;
    bit rd_e;
    int ld;
    rd_e = 1'b0;
    #1;
    if (!rstN) begin
      chk("rst_rdEn", 32'(rdEn), 32'd0);
      chk("rst_outValid", 32'(outValid), 32'd0);
      chk("rst_outData", 32'(outData), 32'd0);
    end else begin
      xfer_e = (cnt_m != 0) && (outReady === 1'b1);
      ld     = cnt_m + int'(inf_m) - int'(xfer_e);
      rd_e   = (fifo_q.size() != 0) && (ld <= 1);
      if (ld > max_load) max_load = ld;
      chk("outValid", 32'(outValid), 32'(cnt_m != 0));
      chk("rdEn", 32'(rdEn), 32'(rd_e));
      if (cnt_m != 0 && exp_q.size() != 0) chk("outData", 32'(outData), 32'(exp_q[0]));
`ifdef FIFO_RD_ADAPTER_CNT_EN
      chk("xferCount", 32'(xferCount), 32'(xc_m));
`endif
      if (xfer_e) begin
        if (first_xfer < 0) begin
          first_xfer = step_n;
          first_data = outData;
        end
        last_xfer = step_n;
        n_xfer++;
        xc_m = xc_m + 16'd1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      cnt_m = ld;
      inf_m = rd_e;
    end
    @(posedge clk);
    #1;
    if (rd_e) begin
      dataIn = fifo_q.pop_front();
      pops++;
    end
    empty = (fifo_q.size() == 0);
    @(negedge clk);
    step_n++;
  endtask

  task automatic drain(input int max_steps);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || cnt_m != 0) && k < max_steps) begin
      step();
      k++;
    end
  endtask

  initial begin
    rstN = 1'b0; empty = 1'b1; outReady = 1'b1; dataIn = '0;
    @(negedge clk);

    // Reset with data available and downstream ready
    load_words(8, 0);
    repeat (3) step();
    rstN = 1'b1;

    // Streaming 0..7
    new_phase();
    drain(40);
    repeat (2) step();
    chk("stream_count", 32'(n_xfer), 32'd8);
    chk("stream_first_cycle", 32'(first_xfer), 32'd2);
    chk("stream_back_to_back", 32'(last_xfer - first_xfer), 32'd7);
    chk("stream_idle_rdEn", 32'(rdEn), 32'd0);

    // Backpressure hold then release
    new_phase();
    load_words(8, 0);
    outReady = 1'b0;
    repeat (10) step();
    chk("bp_pops", 32'(pops), 32'd2);
    chk("bp_held_data", 32'(outData), 32'd0);
    chk("bp_held_valid", 32'(outValid), 32'd1);
    outReady = 1'b1;
    drain(40);
    chk("bp_count", 32'(n_xfer), 32'd8);

    // Alternating ready
    new_phase();
    load_words(8, 8'h30);
    begin
      int k;
      k = 0;
      while ((exp_q.size() != 0 || cnt_m != 0) && k < 60) begin
        outReady = (k % 2 == 0);
        step();
        k++;
      end
    end
    outReady = 1'b1;
    chk("alt_count", 32'(n_xfer), 32'd8);
    chk("alt_max_occupancy", 32'(max_load <= 2), 32'd1);

    // Mid-stream reset after three deliveries
    new_phase();
    load_words(8, 8'h10);
    begin
      int k;
      k = 0;
      while (n_xfer < 3 && k < 20) begin
        step();
        k++;
      end
    end
    chk("mid_pre_count", 32'(n_xfer), 32'd3);
    rstN = 1'b0;
    #1;
    chk("mid_rst_outValid", 32'(outValid), 32'd0);
    chk("mid_rst_outData", 32'(outData), 32'd0);
    clear_model();
    empty = 1'b1;
    step();
    load_words(4, 8'hA0);
    step();
    rstN = 1'b1;
    new_phase();
    drain(30);
    chk("mid_refill_count", 32'(n_xfer), 32'd4);
    chk("mid_refill_first", 32'(first_data), 32'hA0);

`ifdef FIFO_RD_ADAPTER_CNT_EN
    // Transfer counter and its 16-bit wrap
    rstN = 1'b0;
    clear_model();
    empty = 1'b1;
    step();
    rstN = 1'b1;
    new_phase();
    load_words(12, 0);
    drain(40);
    step();
    chk("cnt_12", 32'(xferCount), 32'd12);
    load_words(65536 - 12, 0);
    drain(66000);
    step();
    chk("cnt_wrap", 32'(xferCount), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
